// File: rtl/seven_seg_scan_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan controller.
package seven_seg_scan_pkg;

  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned MAX_DIGITS = 8;

  // Digit-index width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned MAX_IDX_W = idx_width(MAX_DIGITS);

  // Map a logical "digit selected" flag onto the physical enable level.
  function automatic logic en_level(input logic active, input logic active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Load/value side and decoder-facing side of the scan controller.
interface seven_seg_scan_if
  import seven_seg_scan_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4
);

  logic                         i_LOAD;
  logic [NIBBLE_W*N_DIGITS-1:0] i_VALUE;
  logic                         i_BLANK_LZ;
  logic [NIBBLE_W-1:0]          o_NIBBLE;
  logic [N_DIGITS-1:0]          o_DIGIT_EN;
  logic                         o_BLANK;
  logic                         o_FRAME_DONE;

  modport master (
    output i_LOAD, i_VALUE, i_BLANK_LZ,
    input  o_NIBBLE, o_DIGIT_EN, o_BLANK, o_FRAME_DONE
  );

  modport slave (
    input  i_LOAD, i_VALUE, i_BLANK_LZ,
    output o_NIBBLE, o_DIGIT_EN, o_BLANK, o_FRAME_DONE
  );

endinterface

// File: rtl/seven_seg_scan_lz_blank_mask.sv
// Leading-zero blank mask: bit k set when k > 0 and digits k..N_DIGITS-1 are all zero.
// Only digits 1..N_DIGITS-1 are taken, since digit 0 is never blanked.
module seven_seg_scan_lz_blank_mask
  import seven_seg_scan_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4
) (
  input  logic [NIBBLE_W*(N_DIGITS-1)-1:0] upper_digits,
  output logic [N_DIGITS-1:0]              mask
);

  logic zero_run;

  // Walk from the most significant digit down while the zero run holds.
  always_comb begin
    mask     = '0;
    zero_run = 1'b1;
    for (int k = int'(N_DIGITS) - 1; k >= 1; k--) begin
      zero_run = zero_run & (upper_digits[(k-1)*NIBBLE_W +: NIBBLE_W] == '0);
      mask[k]  = zero_run;
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scan controller: slot prescaler, digit index,
// frame-aligned value swap, anti-ghosting gap and leading-zero blanking.
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter int unsigned BLANK_CYCLES  = 500,
  parameter bit          EN_ACTIVE_LOW = 1'b1
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  seven_seg_scan_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(N_DIGITS);
  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam int unsigned VAL_W = NIBBLE_W * N_DIGITS;
  localparam logic [N_DIGITS-1:0] EN_OFF = {N_DIGITS{EN_ACTIVE_LOW}};

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [VAL_W-1:0]    disp_q, disp_d;
  logic [VAL_W-1:0]    pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  logic                blz_q, blz_d;
  logic [NIBBLE_W-1:0] nibble_q, nibble_d;
  logic [N_DIGITS-1:0] en_q, en_d;
  logic                blank_q, blank_d;
  logic                fd_q, fd_d;

  logic                slot_end, last_idx, swap, gap, hide, lz_hit;
  logic [N_DIGITS-1:0] lz_mask;

  seven_seg_scan_lz_blank_mask #(
    .N_DIGITS (N_DIGITS)
  ) u_lz_mask (
    .upper_digits (disp_q[VAL_W-1:NIBBLE_W]),
    .mask         (lz_mask)
  );

  // Next-state for counters, value registers and the registered outputs.
  always_comb begin
    presc_d  = presc_q;
    idx_d    = idx_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    blz_d    = blz_q;
    nibble_d = '0;
    en_d     = EN_OFF;
    lz_hit   = 1'b0;

    slot_end = (presc_q == PRE_W'(REFRESH_DIV - 1));
    last_idx = (idx_q == IDX_W'(N_DIGITS - 1));
    swap     = slot_end & last_idx;

    presc_d = slot_end ? '0 : presc_q + PRE_W'(1);
    if (slot_end) begin
      idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
    end

    if (swap && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
      blz_d    = bus.i_BLANK_LZ;
    end
    // A load on the swap cycle lands in pending for the following frame.
    if (bus.i_LOAD) begin
      pend_d   = bus.i_VALUE;
      pend_v_d = 1'b1;
    end

    for (int k = 0; k < int'(N_DIGITS); k++) begin
      if (idx_q == IDX_W'(k)) begin
        nibble_d = disp_q[k*NIBBLE_W +: NIBBLE_W];
        lz_hit   = lz_mask[k];
      end
    end

    gap  = (presc_q < PRE_W'(BLANK_CYCLES));
    hide = gap | (blz_q & lz_hit);
    for (int k = 0; k < int'(N_DIGITS); k++) begin
      en_d[k] = en_level(!hide && (idx_q == IDX_W'(k)), EN_ACTIVE_LOW);
    end
    blank_d = hide;
    fd_d    = swap;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      presc_q  <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      blz_q    <= 1'b0;
      nibble_q <= '0;
      en_q     <= EN_OFF;
      blank_q  <= 1'b1;
      fd_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      blz_q    <= blz_d;
      nibble_q <= nibble_d;
      en_q     <= en_d;
      blank_q  <= blank_d;
      fd_q     <= fd_d;
    end
  end

  assign bus.o_NIBBLE     = nibble_q;
  assign bus.o_DIGIT_EN   = en_q;
  assign bus.o_BLANK      = blank_q;
  assign bus.o_FRAME_DONE = fd_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan against a frame-level reference model.
module tb_seven_seg_scan;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = ND * RD;
  localparam logic [9:0] RST_VEC = {4'h0, 4'hF, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  seven_seg_scan_if #(.N_DIGITS(ND)) bus ();

  seven_seg_scan #(
    .N_DIGITS      (ND),
    .REFRESH_DIV   (RD),
    .BLANK_CYCLES  (BC),
    .EN_ACTIVE_LOW (1'b1)
  ) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [9:0] dut_vec;
  assign dut_vec = {bus.o_NIBBLE, bus.o_DIGIT_EN, bus.o_BLANK, bus.o_FRAME_DONE};

  // Reference model: absolute cycle count since reset gives slot and phase.
  int          m_t;
  logic [15:0] m_disp, m_pend;
  bit          m_pv, m_blz;
  logic [9:0]  exp_vec;
  int          m_slot, m_phase;
  bit          m_hide, m_fend;
  logic [3:0]  m_en, m_nib;

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; m_disp = '0; m_pend = '0; m_pv = 0; m_blz = 0;
      exp_vec = RST_VEC;
    end else begin
      m_slot  = (m_t / RD) % ND;
      m_phase = m_t % RD;
      m_hide  = (m_phase < BC) || (m_blz && m_slot > 0 && (m_disp >> (4 * m_slot)) == 0);
      m_nib   = 4'((m_disp >> (4 * m_slot)) & 16'hF);
      m_en    = m_hide ? 4'hF : ~(4'(1) << m_slot);
      m_fend  = (m_t % FRAME) == FRAME - 1;
      exp_vec = {m_nib, m_en, m_hide, m_fend};
      if (m_fend && m_pv) begin
        m_disp = m_pend; m_pv = 0; m_blz = bus.i_BLANK_LZ;
      end
      if (bus.i_LOAD) begin
        m_pend = bus.i_VALUE; m_pv = 1;
      end
      m_t++;
    end
  end

  // Park at the negedge that precedes the edge with model phase ph in the frame.
  task automatic wait_phase(input int ph, output bit ok);
    ok = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (m_t % FRAME == ph) begin ok = 1; break; end
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    bus.i_VALUE = v; bus.i_LOAD = 1'b1;
    @(negedge clk);
    bus.i_LOAD = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.i_LOAD = 1'b1; bus.i_VALUE = 16'hBEEF; bus.i_BLANK_LZ = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dut_vec !== RST_VEC) begin
      n_err++; $display("FAIL reset: got %h expected %h", dut_vec, RST_VEC);
    end
    bus.i_LOAD = 1'b0; bus.i_BLANK_LZ = 1'b0; rst = 1'b0;
    // A load held during reset must be dropped: display stays zero.
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk); n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL idle t=%0d: got %h expected %h", m_t, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_first_slot;
    logic [3:0] en_seq [8];
    en_seq = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD};
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); n_checks++;
      if (bus.o_DIGIT_EN !== en_seq[i]) begin
        n_err++; $display("FAIL first_slot c=%0d: en %b expected %b", i, bus.o_DIGIT_EN, en_seq[i]);
      end
    end
  endtask

  task automatic test_midframe_load;
    bit ok;
    wait_phase(6, ok); n_checks++;
    if (!ok) begin n_err++; $display("FAIL midframe_wait: timeout got 0 expected 1"); end
    pulse_load(16'h1A2F);
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      @(negedge clk); n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL midframe t=%0d: got %h expected %h", m_t, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_last_wins;
    bit ok;
    wait_phase(2, ok); n_checks++;
    if (!ok) begin n_err++; $display("FAIL lastwins_wait: timeout got 0 expected 1"); end
    pulse_load(16'h1234);
    @(negedge clk);
    pulse_load(16'h5678);
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      @(negedge clk); n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL lastwins t=%0d: got %h expected %h", m_t, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_lz_blank;
    logic [15:0] vals [2];
    vals = '{16'h0070, 16'h0000};
    bus.i_BLANK_LZ = 1'b1;
    foreach (vals[j]) begin
      pulse_load(vals[j]);
      for (int i = 0; i < 2 * FRAME + 3; i++) begin
        @(negedge clk); n_checks++;
        if (dut_vec !== exp_vec) begin
          n_err++; $display("FAIL lz %h t=%0d: got %h expected %h", vals[j], m_t, dut_vec, exp_vec);
        end
      end
    end
  endtask

  task automatic test_swap_load;
    bit ok;
    bus.i_BLANK_LZ = 1'b0;
    wait_phase(3, ok);
    pulse_load(16'h1111);
    wait_phase(FRAME - 1, ok); n_checks++;
    if (!ok) begin n_err++; $display("FAIL swap_wait: timeout got 0 expected 1"); end
    pulse_load(16'h2222);
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk); n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL swapload t=%0d: got %h expected %h", m_t, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] masks [4];
    masks = '{16'hFFFF, 16'h0FFF, 16'h00F0, 16'h0000};
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL random t=%0d: got %h expected %h", m_t, dut_vec, exp_vec);
      end
      bus.i_LOAD     = ($urandom_range(0, 9) == 0);
      bus.i_VALUE    = 16'($urandom) & masks[$urandom_range(0, 3)];
      bus.i_BLANK_LZ = 1'($urandom);
    end
    bus.i_LOAD = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    bus.i_BLANK_LZ = 1'b0;
    wait_phase(5, ok);
    pulse_load(16'hABCD);
    wait_phase(2 * RD + 1, ok); n_checks++;
    if (!ok) begin n_err++; $display("FAIL resetmid_wait: timeout got 0 expected 1"); end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    n_checks++;
    if (dut_vec !== RST_VEC) begin
      n_err++; $display("FAIL resetmid: got %h expected %h", dut_vec, RST_VEC);
    end
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      @(negedge clk); n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL after_reset t=%0d: got %h expected %h", m_t, dut_vec, exp_vec);
      end
    end
  endtask

  initial begin
    rst = 1'b1; bus.i_LOAD = 1'b0; bus.i_VALUE = '0; bus.i_BLANK_LZ = 1'b0;
    test_reset();
    test_first_slot();
    test_midframe_load();
    test_last_wins();
    test_lz_blank();
    test_swap_load();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
